i2c_target_responder: RTL and testbench

- I2C target (slave) model that sits directly downstream of the I2C transaction generator.
- Consumes scl, sda_out and sda_oe from the generator and drives sda_in back to it.
- Decodes START, address, R/W and STOP; ACKs its own address; captures DATA_W-bit write payloads; serves a DATA_W-bit read payload MSB first.
- Used as the bus-partner stage in the Tarea 4 testbench and as the target side in integration.

---
 rtl/i2c_target_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// I2C target: decodes START/STOP, ACKs i2c_addr, captures DATA_W-bit writes and serves DATA_W-bit reads MSB first.
// Define I2C_TARGET_GENERAL_CALL_EN to also ACK general-call writes (8'h00) and flag them on gc_flag.
module i2c_target_responder #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda_out,
  input  logic              sda_oe,
  input  logic [6:0]        i2c_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              sda_in,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
`ifdef I2C_TARGET_GENERAL_CALL_EN
  output logic              gc_flag,
`endif
  output logic              busy
);
  localparam int NBYTES = DATA_W / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(NBYTES - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE, WAIT_STOP
  } state_t;

  state_t            state, state_d;
  logic              scl_q, sda_q;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [BCW-1:0]    byte_cnt, byte_cnt_d;
  logic              byte_done, byte_done_d;
  logic              rw, rw_d;
  logic              mack, mack_d;
  logic [6:0]        addr_sr, addr_sr_d;
  logic [DATA_W-1:0] wr_sr, wr_sr_d, rd_sr, rd_sr_d, wr_data_d;
  logic              sda_in_d, wr_valid_d, busy_d;
  logic              sda_line, start, stop, rise, fall;
  logic [7:0]        addr_byte;
  logic              gc_hit, addr_hit;

  // Wired-AND of master and target drivers, as seen on the physical line
  assign sda_line  = (sda_oe ? sda_out : 1'b1) & sda_in;
  assign start     = scl & scl_q & sda_q & ~sda_line;
  assign stop      = scl & scl_q & ~sda_q & sda_line;
  assign rise      = scl & ~scl_q;
  assign fall      = ~scl & scl_q;
  assign addr_byte = {addr_sr, sda_line};

`ifdef I2C_TARGET_GENERAL_CALL_EN
  assign gc_hit = (addr_byte == 8'h00);
`else
  assign gc_hit = 1'b0;
`endif
  assign addr_hit = (addr_byte[7:1] == i2c_addr) | gc_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      mack      <= 1'b1;
      addr_sr   <= '0;
      wr_sr     <= '0;
      rd_sr     <= '0;
      wr_data   <= '0;
      sda_in    <= 1'b1;
      wr_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      scl_q     <= scl;
      sda_q     <= sda_line;
      bit_cnt   <= bit_cnt_d;
      byte_cnt  <= byte_cnt_d;
      byte_done <= byte_done_d;
      rw        <= rw_d;
      mack      <= mack_d;
      addr_sr   <= addr_sr_d;
      wr_sr     <= wr_sr_d;
      rd_sr     <= rd_sr_d;
      wr_data   <= wr_data_d;
      sda_in    <= sda_in_d;
      wr_valid  <= wr_valid_d;
      busy      <= busy_d;
    end
  end

  // sda_in only ever changes on an scl fall, so the target can never fake a START/STOP
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    byte_cnt_d  = byte_cnt;
    byte_done_d = byte_done;
    rw_d        = rw;
    mack_d      = mack;
    addr_sr_d   = addr_sr;
    wr_sr_d     = wr_sr;
    rd_sr_d     = rd_sr;
    wr_data_d   = wr_data;
    sda_in_d    = sda_in;
    wr_valid_d  = 1'b0;
    busy_d      = busy;
    if (start) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd7;
      byte_cnt_d  = '0;
      byte_done_d = 1'b0;
      busy_d      = 1'b1;
      sda_in_d    = 1'b1;
    end else if (stop) begin
      state_d     = IDLE;
      byte_done_d = 1'b0;
      busy_d      = 1'b0;
      sda_in_d    = 1'b1;
    end else begin
      case (state)
        IDLE: sda_in_d = 1'b1;
        ADDR: begin
          if (rise) begin
            addr_sr_d = addr_byte[6:0];
            bit_cnt_d = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              rw_d = addr_byte[0];
              if (addr_hit) byte_done_d = 1'b1;
              else          state_d     = IGNORE;
            end
          end else if (fall && byte_done) begin
            byte_done_d = 1'b0;
            sda_in_d    = 1'b0;
            state_d     = ADDR_ACK;
            if (rw) rd_sr_d = rd_data;
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            bit_cnt_d = 3'd7;
            if (rw) begin
              sda_in_d = rd_sr[DATA_W-1];
              rd_sr_d  = {rd_sr[DATA_W-2:0], 1'b0};
              state_d  = RD_BYTE;
            end else begin
              sda_in_d = 1'b1;
              state_d  = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (rise) begin
            wr_sr_d   = {wr_sr[DATA_W-2:0], sda_line};
            bit_cnt_d = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) byte_done_d = 1'b1;
          end else if (fall && byte_done) begin
            byte_done_d = 1'b0;
            sda_in_d    = 1'b0;
            state_d     = WR_ACK;
          end
        end
        WR_ACK: begin
          if (fall) begin
            sda_in_d = 1'b1;
            if (byte_cnt == LAST) begin
              wr_data_d  = wr_sr;
              wr_valid_d = 1'b1;
              state_d    = WAIT_STOP;
            end else begin
              byte_cnt_d = byte_cnt + BCW'(1);
              bit_cnt_d  = 3'd7;
              state_d    = WR_BYTE;
            end
          end
        end
        RD_BYTE: begin
          // bit_cnt counts the falls left in this byte; the eighth fall releases for the master ACK
          if (fall) begin
            if (bit_cnt == 3'd0) begin
              sda_in_d = 1'b1;
              state_d  = RD_ACK;
            end else begin
              sda_in_d  = rd_sr[DATA_W-1];
              rd_sr_d   = {rd_sr[DATA_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt - 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (rise) begin
            mack_d = sda_line;
          end else if (fall) begin
            if (!mack && byte_cnt != LAST) begin
              byte_cnt_d = byte_cnt + BCW'(1);
              sda_in_d   = rd_sr[DATA_W-1];
              rd_sr_d    = {rd_sr[DATA_W-2:0], 1'b0};
              bit_cnt_d  = 3'd7;
              state_d    = RD_BYTE;
            end else begin
              sda_in_d = 1'b1;
              state_d  = WAIT_STOP;
            end
          end
        end
        IGNORE, WAIT_STOP: sda_in_d = 1'b1;
        default: begin
          state_d  = IDLE;
          sda_in_d = 1'b1;
        end
      endcase
    end
  end

`ifdef I2C_TARGET_GENERAL_CALL_EN
  logic gc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       gc_q <= 1'b0;
    else if (start)                                gc_q <= 1'b0;
    else if (state == ADDR && rise && bit_cnt == 3'd0) gc_q <= gc_hit;
  end
  assign gc_flag = wr_valid & gc_q;
`endif

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-level I2C master, transaction-level model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_i2c_target_responder;
  localparam int DATA_W = 16;
  localparam int NB     = DATA_W / 8;
  localparam int Q      = 3;
  localparam logic [6:0] MY_ADDR = 7'h2A;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              scl = 1'b1, sda_out = 1'b1, sda_oe = 1'b0;
  logic [6:0]        i2c_addr = MY_ADDR;
  logic [DATA_W-1:0] rd_data = '0;
  logic              sda_in, wr_valid, busy;
  logic [DATA_W-1:0] wr_data;
`ifdef I2C_TARGET_GENERAL_CALL_EN
  logic              gc_flag;
`endif

  i2c_target_responder #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_out(sda_out), .sda_oe(sda_oe),
    .i2c_addr(i2c_addr), .rd_data(rd_data), .sda_in(sda_in),
    .wr_data(wr_data), .wr_valid(wr_valid),
`ifdef I2C_TARGET_GENERAL_CALL_EN
    .gc_flag(gc_flag),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DATA_W-1:0] data; logic gc; } wexp_t;
  wexp_t             exp_q[$];
  wexp_t             e;
  logic [DATA_W-1:0] exp_wr_data = '0;
  logic              exp_busy = 1'b0;
  bit                mask = 1'b1;
  int                checks = 0, errors = 0;
  int                cyc = 0, fall_cyc = -100, vld_cnt = 0;
  logic              prev_scl = 1'b1, prev_sda = 1'b1, prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Target ACKs its own address, plus the general call when that option is built in
  function automatic bit addr_acked(input logic [7:0] b);
    if (b[7:1] == MY_ADDR) return 1'b1;
`ifdef I2C_TARGET_GENERAL_CALL_EN
    if (b == 8'h00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Per-cycle compare against the model, sampled 1ns after the active edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!mask) begin
        chk("busy", busy, exp_busy);
        if (wr_valid) begin
          vld_cnt++;
          chk("wr_valid_width", prev_vld, 1'b0);
          chk("wr_valid_latency", cyc - fall_cyc, 1);
          chk("wr_valid_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_wr_data = e.data;
`ifdef I2C_TARGET_GENERAL_CALL_EN
            chk("gc_flag", gc_flag, e.gc);
`endif
          end
        end
`ifdef I2C_TARGET_GENERAL_CALL_EN
        else chk("gc_flag_idle", gc_flag, 1'b0);
`endif
        chk("wr_data", wr_data, exp_wr_data);
        if (scl && prev_scl) chk("sda_stable_scl_high", sda_in, prev_sda);
      end
      prev_scl = scl;
      prev_sda = sda_in;
      prev_vld = wr_valid;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_oe = 1'b1; sda_out = 1'b0; exp_busy = 1'b1;
    clks(2*Q); scl = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    sda_oe = 1'b1; sda_out = 1'b0; clks(Q);
    scl = 1'b1; clks(Q);
    sda_oe = 1'b0; sda_out = 1'b1; exp_busy = 1'b0; clks(2*Q);
  endtask

  task automatic put_bit(input logic b);
    sda_oe = 1'b1; sda_out = b; clks(Q);
    scl = 1'b1; clks(2*Q);
    scl = 1'b0; fall_cyc = cyc; clks(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_oe = 1'b0; clks(Q);
    scl = 1'b1; clks(Q);
    b = (sda_oe ? sda_out : 1'b1) & sda_in;
    clks(Q);
    scl = 1'b0; fall_cyc = cyc; clks(Q);
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] v, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(mack);
  endtask

  task automatic write_txn(input logic [7:0] ab, input logic [DATA_W-1:0] d, input string tag);
    logic a;
    bit   exp_ack;
    exp_ack = addr_acked(ab);
    i2c_start();
    put_byte(ab, a);
    chk({tag, "_addr_ack"}, a, !exp_ack);
    for (int k = NB-1; k >= 0; k--) begin
      for (int i = 7; i >= 0; i--) put_bit(d[k*8+i]);
      if (k == 0 && exp_ack) exp_q.push_back('{data: d, gc: (ab == 8'h00)});
      get_bit(a);
      chk({tag, "_data_ack"}, a, !exp_ack);
    end
    i2c_stop();
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic read_txn(input logic [7:0] ab, input logic [DATA_W-1:0] rd_after,
                          output logic [DATA_W-1:0] got);
    logic a;
    logic [7:0] by;
    logic [DATA_W-1:0] expv;
    expv = rd_data;
    i2c_start();
    put_byte(ab, a);
    chk("rd_addr_ack", a, 1'b0);
    rd_data = rd_after;
    for (int k = NB-1; k >= 0; k--) begin
      get_byte(by, (k == 0));
      chk("rd_byte", by, expv[k*8 +: 8]);
      got[k*8 +: 8] = by;
    end
    i2c_stop();
  endtask

  initial begin
    logic a;
    logic [DATA_W-1:0] got;
    clks(4);
    chk("reset_sda_in", sda_in, 1'b1);
    chk("reset_wr_data", wr_data, '0);
    chk("reset_wr_valid", wr_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    clks(4);
    mask = 1'b0;

    // 1: full write to own address
    write_txn(8'h54, 16'hA5C3, "t1");
    chk("t1_wr_data", wr_data, 16'hA5C3);
    chk("t1_vld_cnt", vld_cnt, 1);
    chk("t1_busy_after_stop", busy, 1'b0);

    // 2: read, with rd_data disturbed after the address ACK
    rd_data = 16'h3C96;
    read_txn(8'h55, 16'hFFFF, got);
    chk("t2_rd_result", got, 16'h3C96);
    rd_data = '0;

    // 3: foreign address is NACKed and ignored
    write_txn(8'h22, 16'hFFFF, "t3");
    chk("t3_vld_cnt", vld_cnt, 1);
    chk("t3_wr_data", wr_data, 16'hA5C3);

    // 4: STOP after 5 data bits aborts, then a clean write
    i2c_start();
    put_byte(8'h54, a);
    chk("t4_addr_ack", a, 1'b0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    chk("t4_abort_wr_data", wr_data, 16'hA5C3);
    chk("t4_abort_vld_cnt", vld_cnt, 1);
    write_txn(8'h54, 16'h1234, "t4b");
    chk("t4_wr_data", wr_data, 16'h1234);
    chk("t4_vld_cnt", vld_cnt, 2);

    // 5: asynchronous reset while the target drives a 0 read bit
    rd_data = 16'h3C96;
    i2c_start();
    put_byte(8'h55, a);
    chk("t5_addr_ack", a, 1'b0);
    chk("t5_sda_driven", sda_in, 1'b0);
    mask = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t5_sda_released", sda_in, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_wr_data", wr_data, '0);
    scl = 1'b1; sda_oe = 1'b0; sda_out = 1'b1;
    clks(2);
    rst = 1'b0;
    exp_busy = 1'b0;
    exp_wr_data = '0;
    rd_data = '0;
    clks(4);
    mask = 1'b0;

    // 6: general call
    write_txn(8'h00, 16'hBEEF, "t6");
`ifdef I2C_TARGET_GENERAL_CALL_EN
    chk("t6_wr_data", wr_data, 16'hBEEF);
    chk("t6_vld_cnt", vld_cnt, 3);
`else
    chk("t6_wr_data", wr_data, '0);
    chk("t6_vld_cnt", vld_cnt, 2);
`endif

    clks(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
